// File: rtl/dsp_tasks_ctrl.sv
// dsp_tasks_ctrl -- Wishbone test-task sequencer.
// Runs one bus command at a time (WRITE, READ_CHECK, POLL, NOP) and keeps a
// running test verdict (sticky test_failed, saturating fail_count).
//
// Ports:
//   clk_tb, reset_tb          clock, asynchronous active-low reset
//   cmd_valid/op/adr/data/mask command request (sampled only when idle)
//   busy, done, pass, fail     command status; pass/fail valid with done
//   rdata                      last data read from the bus
//   test_failed, fail_count    accumulated verdict
//   wb_*_o / wb_*_i            Wishbone master
//
// Build option: define DSP_TASKS_TIMEOUT_EN to add an ack watchdog of
// TIMEOUT_CYCLES WAIT cycles; without it WAIT has no time limit.
module dsp_tasks_ctrl #(
  parameter logic [31:0] BASE_ADR       = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_tb,
  input  logic        reset_tb,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] rdata,
  output logic        test_failed,
  output logic [7:0]  fail_count,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, GAP, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_cmd_adr, r_cmd_data, r_cmd_mask;
  logic        r_busy, r_done, r_pass, r_fail, r_test_failed;
  logic [7:0]  r_fail_count;
  logic [31:0] r_rdata;
  logic        r_cyc, r_stb, r_we;
  logic [31:0] r_wb_adr, r_wb_dat;
  logic [3:0]  r_sel;
  logic        r_result;     // verdict carried into DONE, 1 = pass
  logic [1:0]  r_gap_cnt;
  logic [31:0] r_poll_cnt;   // completed reads of the current POLL
`ifdef DSP_TASKS_TIMEOUT_EN
  logic [31:0] r_to_cnt;
`else
  logic        w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic w_match;
  assign w_match = ((r_rdata & r_cmd_mask) == (r_cmd_data & r_cmd_mask));

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      r_state       <= IDLE;
      r_op          <= OP_NOP;
      r_cmd_adr     <= '0;
      r_cmd_data    <= '0;
      r_cmd_mask    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_test_failed <= 1'b0;
      r_fail_count  <= '0;
      r_rdata       <= '0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_wb_adr      <= '0;
      r_wb_dat      <= '0;
      r_sel         <= '0;
      r_result      <= 1'b0;
      r_gap_cnt     <= '0;
      r_poll_cnt    <= '0;
`ifdef DSP_TASKS_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op       <= cmd_op;
            r_cmd_adr  <= cmd_adr;
            r_cmd_data <= cmd_data;
            r_cmd_mask <= cmd_mask;
            r_busy     <= 1'b1;
            r_poll_cnt <= '0;
            if (cmd_op == OP_NOP) begin
              r_result <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state  <= REQ;
            end
          end
        end
        REQ: begin
          r_cyc    <= 1'b1;
          r_stb    <= 1'b1;
          r_sel    <= 4'hF;
          r_wb_adr <= BASE_ADR + r_cmd_adr;
          r_we     <= (r_op == OP_WRITE);
          r_wb_dat <= r_cmd_data;
`ifdef DSP_TASKS_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state  <= WAIT;
        end
        WAIT: begin
          // err outranks ack when both arrive together
          if (wb_err_i) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_result <= 1'b0;
            r_state  <= DONE;
          end else if (wb_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            if (r_op == OP_WRITE) begin
              r_result <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rdata <= wb_dat_i;
              if (r_op == OP_POLL) r_poll_cnt <= r_poll_cnt + 32'd1;
              r_state <= CHECK;
            end
          end else if (wb_rty_i) begin
            // REQ itself provides the single idle cycle before re-issue
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= REQ;
          end
`ifdef DSP_TASKS_TIMEOUT_EN
          else if (r_to_cnt == TIMEOUT_CYCLES - 1) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_result <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`endif
        end
        CHECK: begin
          if (w_match) begin
            r_result <= 1'b1;
            r_state  <= DONE;
          end else if (r_op != OP_POLL || r_poll_cnt >= POLL_LIMIT) begin
            r_result <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == 2'd3) r_state <= REQ;
          else                   r_gap_cnt <= r_gap_cnt + 2'd1;
        end
        DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= r_result;
          r_fail <= ~r_result;
          if (!r_result) begin
            r_test_failed <= 1'b1;
            if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign rdata       = r_rdata;
  assign test_failed = r_test_failed;
  assign fail_count  = r_fail_count;
  assign wb_adr_o    = r_wb_adr;
  assign wb_dat_o    = r_wb_dat;
  assign wb_sel_o    = r_sel;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_stb;
  assign wb_we_o     = r_we;

endmodule

// File: tb/tb_dsp_tasks_ctrl.sv
// tb_dsp_tasks_ctrl -- directed bench for dsp_tasks_ctrl with a small
// Wishbone slave model (programmable delay, response type, read data).
// Build with DSP_TASKS_TIMEOUT_EN defined to exercise the ack watchdog.
module tb_dsp_tasks_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_POLL = 2'b10, OP_NOP = 2'b11;
  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3;

  logic        clk_tb = 1'b0;
  logic        reset_tb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_adr = '0, cmd_data = '0, cmd_mask = '0;
  logic        busy, done, pass, fail, test_failed;
  logic [31:0] rdata;
  logic [7:0]  fail_count;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  dsp_tasks_ctrl #(.BASE_ADR(BASE)) dut (
    .clk_tb(clk_tb), .reset_tb(reset_tb),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_adr(cmd_adr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .rdata(rdata),
    .test_failed(test_failed), .fail_count(fail_count),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  always #5 clk_tb = ~clk_tb;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model settings
  int          s_delay = 0;
  int          s_resp = R_ACK;
  int          s_rty_left = 0;
  int          s_reads = 0;
  bit          s_poll = 1'b0;
  logic [31:0] s_data = '0;
  int          s_wait = 0;

  // Responds s_delay cycles after cyc is first seen; poll mode makes bit0
  // go high from the 3rd acked read on.
  always @(negedge clk_tb) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = s_poll ? {31'b0, (s_reads >= 2)} : s_data;
    if (wb_cyc_o && wb_stb_o && s_resp != R_NONE) begin
      if (s_wait >= s_delay) begin
        s_wait = 0;
        if (s_rty_left > 0) begin
          wb_rty_i = 1'b1;
          s_rty_left--;
        end else if (s_resp == R_ACK) begin
          wb_ack_i = 1'b1;
          s_reads++;
        end else if (s_resp == R_ERR) begin
          wb_err_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          wb_err_i = 1'b1;
        end
      end else begin
        s_wait++;
      end
    end else begin
      s_wait = 0;
    end
  end

  // Per-command observations
  int          lat, n_bus, cyc_hi;
  int          gap_q[$];
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we, got_done;

  task automatic start_cmd(input logic [1:0] op, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [31:0] msk);
    @(negedge clk_tb);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adr   = adr;
    cmd_data  = dat;
    cmd_mask  = msk;
    @(posedge clk_tb);
    #1 cmd_valid = 1'b0;
  endtask

  // lat = clock edges from acceptance to the edge that raises done
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [31:0] msk,
                         input int budget, input int poke_at);
    int  low;
    bit  prev, poked;
    start_cmd(op, adr, dat, msk);
    lat = 0; n_bus = 0; cyc_hi = 0; low = 0; prev = 1'b0; poked = 1'b0;
    got_done = 1'b0;
    gap_q.delete();
    while (!got_done && lat < budget) begin
      @(posedge clk_tb);
      if (poked) begin
        #1 cmd_valid = 1'b0;
        poked = 1'b0;
      end
      lat++;
      @(negedge clk_tb);
      if (wb_cyc_o) begin
        cyc_hi++;
        if (!prev) begin
          n_bus++;
          if (n_bus == 1) begin
            cap_adr = wb_adr_o; cap_dat = wb_dat_o;
            cap_sel = wb_sel_o; cap_we  = wb_we_o;
          end else begin
            gap_q.push_back(low);
          end
        end
        low = 0;
      end else begin
        low++;
      end
      prev = wb_cyc_o;
      if (done) got_done = 1'b1;
      if (lat == poke_at) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WR;
        cmd_adr   = 32'h44;
        poked     = 1'b1;
      end
    end
    if (!got_done) check_val("done_timeout", 32'(got_done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_status"}, {26'b0, busy, done, pass, fail, test_failed, wb_we_o}, '0);
    check_val({tag, "_bus_ctl"}, {26'b0, wb_cyc_o, wb_stb_o, wb_sel_o}, '0);
    check_val({tag, "_rdata"}, rdata, '0);
    check_val({tag, "_fail_count"}, 32'(fail_count), '0);
    check_val({tag, "_adr"}, wb_adr_o, '0);
    check_val({tag, "_dat"}, wb_dat_o, '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_tb);
    check_reset_outputs("reset");
    reset_tb = 1'b1;

    // WRITE with ack after 2 extra cycles
    s_resp = R_ACK; s_delay = 2;
    run_cmd(OP_WR, 32'h10, 32'hDEADBEEF, '0, 50, -1);
    check_val("wr_adr", cap_adr, 32'h1000_0010);
    check_val("wr_dat", cap_dat, 32'hDEADBEEF);
    check_val("wr_we_sel", {27'b0, cap_we, cap_sel}, 32'h1F);
    check_val("wr_lat", 32'(lat), 32'd5);
    check_val("wr_pass_fail_busy", {29'b0, pass, fail, busy}, 32'b100);
    @(negedge clk_tb);
    check_val("wr_done_pulse", 32'(done), 32'd0);

    // Fastest command: ack in the first WAIT cycle
    s_delay = 0;
    run_cmd(OP_WR, 32'h20, 32'h1, '0, 50, -1);
    check_val("fast_wr_lat", 32'(lat), 32'd3);

    // READ_CHECK masked match
    s_data = 32'h12A5;
    run_cmd(OP_RD, 32'h30, 32'h00A5, 32'h00FF, 50, -1);
    check_val("rd_pass", {30'b0, pass, fail}, 32'b10);
    check_val("rd_rdata", rdata, 32'h12A5);
    check_val("rd_we_lat", {cap_we, 31'(lat)}, 32'd4);

    // Read answered with err
    s_resp = R_ERR;
    run_cmd(OP_RD, 32'h30, 32'h0, 32'h0, 50, -1);
    check_val("err_lat", 32'(lat), 32'd3);
    check_val("err_fail", {30'b0, pass, fail}, 32'b01);
    check_val("err_sticky_cnt", {23'b0, test_failed, fail_count}, 32'h101);
    check_val("err_rdata_kept", rdata, 32'h12A5);

    // A later passing command keeps test_failed
    s_resp = R_ACK;
    run_cmd(OP_WR, 32'h40, 32'h2, '0, 50, -1);
    check_val("pass_after_fail", {22'b0, pass, test_failed, fail_count}, 32'h301);

    // READ_CHECK mismatch
    run_cmd(OP_RD, 32'h30, 32'h00A5, 32'hFFFF, 50, -1);
    check_val("rd_mismatch", {22'b0, pass, fail, fail_count}, 32'h102);

    // ack and err together count as err; rdata not captured
    s_resp = R_BOTH; s_data = 32'h5555;
    run_cmd(OP_RD, 32'h30, 32'h5555, '1, 50, -1);
    check_val("ack_err_fail", {23'b0, fail, fail_count}, 32'h103);
    check_val("ack_err_rdata", rdata, 32'h12A5);

    // rty once, then ack: re-issue after exactly one idle cycle
    s_resp = R_ACK; s_rty_left = 1;
    run_cmd(OP_RD, 32'h50, 32'h5555, '1, 50, -1);
    check_val("rty_bus_cycles", 32'(n_bus), 32'd2);
    check_val("rty_gap", (gap_q.size() > 0) ? 32'(gap_q[0]) : 32'hFFFF_FFFF, 32'd1);
    check_val("rty_lat", 32'(lat), 32'd6);
    check_val("rty_pass", {31'b0, pass}, 32'd1);

    // POLL: bit0 rises on the 3rd read. cyc is low for CHECK + 4 GAP + REQ.
    s_poll = 1'b1; s_reads = 0;
    run_cmd(OP_POLL, 32'h60, 32'h1, 32'h1, 100, -1);
    check_val("poll_bus_cycles", 32'(n_bus), 32'd3);
    check_val("poll_gap0", (gap_q.size() > 0) ? 32'(gap_q[0]) : 32'hFFFF_FFFF, 32'd6);
    check_val("poll_gap1", (gap_q.size() > 1) ? 32'(gap_q[1]) : 32'hFFFF_FFFF, 32'd6);
    check_val("poll_lat", 32'(lat), 32'd18);
    check_val("poll_pass", {30'b0, pass, fail}, 32'b10);
    check_val("poll_rdata", rdata, 32'h1);

    // POLL never matching: exactly POLL_LIMIT reads then fail
    s_poll = 1'b0; s_data = 32'h0;
    run_cmd(OP_POLL, 32'h60, 32'h1, 32'h1, 3000, -1);
    check_val("poll_limit_reads", 32'(n_bus), 32'd256);
    check_val("poll_limit_lat", 32'(lat), 32'd1789);
    check_val("poll_limit_fail", {23'b0, fail, fail_count}, 32'h104);

    // NOP completes without touching the bus
    run_cmd(OP_NOP, 32'h0, 32'h0, 32'h0, 50, -1);
    check_val("nop", {pass, 7'(n_bus), 24'(lat)}, 32'h8000_0001);

    // cmd_valid while busy is ignored
    s_delay = 3; s_data = 32'h77;
    run_cmd(OP_RD, 32'h70, 32'h77, 32'hFF, 50, 2);
    check_val("busy_ignore_bus", 32'(n_bus), 32'd1);
    check_val("busy_ignore_pass", {31'b0, pass}, 32'd1);
    repeat (4) @(negedge clk_tb);
    check_val("busy_ignore_idle", {30'b0, wb_cyc_o, busy}, 32'd0);

    // fail_count saturates at 255
    s_resp = R_ERR; s_delay = 0;
    for (int unsigned i = 0; i < 260; i++) run_cmd(OP_RD, 32'h0, 32'h0, 32'h0, 50, -1);
    check_val("fail_count_sat", {23'b0, test_failed, fail_count}, 32'h1FF);

    s_resp = R_NONE;
`ifdef DSP_TASKS_TIMEOUT_EN
    // Watchdog: cyc high for 1024 WAIT cycles, then fail
    run_cmd(OP_RD, 32'h80, 32'h0, 32'h0, 1200, -1);
    check_val("timeout_cyc_hi", 32'(cyc_hi), 32'd1024);
    check_val("timeout_lat", 32'(lat), 32'd1026);
    check_val("timeout_fail", {30'b0, fail, wb_cyc_o}, 32'b10);
    check_val("timeout_sat", 32'(fail_count), 32'hFF);
    start_cmd(OP_RD, 32'h80, 32'h0, 32'h0);
    repeat (20) @(negedge clk_tb);
`else
    // No watchdog: WAIT holds indefinitely
    start_cmd(OP_RD, 32'h80, 32'h0, 32'h0);
    repeat (1100) @(negedge clk_tb);
`endif
    check_val("wait_hold", {29'b0, wb_cyc_o, wb_stb_o, busy}, 32'b111);
    check_val("wait_hold_adr", wb_adr_o, 32'h1000_0080);

    // Asynchronous reset mid-WAIT, away from any clock edge
    #2 reset_tb = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk_tb);
    reset_tb = 1'b1;

    // Back in IDLE: NOP and a fast write behave as from reset
    run_cmd(OP_NOP, 32'h0, 32'h0, 32'h0, 50, -1);
    check_val("post_reset_nop_lat", 32'(lat), 32'd1);
    s_resp = R_ACK;
    run_cmd(OP_WR, 32'h8, 32'h9, '0, 50, -1);
    check_val("post_reset_wr", {pass, test_failed, 22'(lat), fail_count}, 32'h8000_0300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
